// File: rtl/falconsoar_pkg.sv
// Shared types for the exec-operator dispatcher: FSM states, queued command record, operator ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package falconsoar_pkg;

   localparam int DSP_OP_W   = 4;
   localparam int DSP_ADDR_W = 8;

   typedef enum logic [1:0] {
      DSP_IDLE  = 2'd0,
      DSP_ISSUE = 2'd1,
      DSP_WAIT  = 2'd2,
      DSP_ERR   = 2'd3
   } dsp_state_e;

   typedef struct packed {
      logic [DSP_OP_W-1:0]   op;
      logic [DSP_ADDR_W-1:0] src;
      logic [DSP_ADDR_W-1:0] dst;
   } dsp_cmd_t;

   // Operator-bank select codes
   localparam logic [DSP_OP_W-1:0] OP_SAMPLERZ = 4'd0;
   localparam logic [DSP_OP_W-1:0] OP_FFT      = 4'd1;
   localparam logic [DSP_OP_W-1:0] OP_IFFT     = 4'd2;
   localparam logic [DSP_OP_W-1:0] OP_NTT      = 4'd3;
   localparam logic [DSP_OP_W-1:0] OP_INTT     = 4'd4;
   localparam logic [DSP_OP_W-1:0] OP_POLYMUL  = 4'd5;

   // Build a command record from its three fields
   function automatic dsp_cmd_t dsp_pack(input logic [DSP_OP_W-1:0]   op,
                                         input logic [DSP_ADDR_W-1:0] src,
                                         input logic [DSP_ADDR_W-1:0] dst);
      dsp_cmd_t c;
      c.op  = op;
      c.src = src;
      c.dst = dst;
      return c;
   endfunction

endpackage

// File: rtl/dsp_cmd_fifo.sv
// Circular command queue with wrap-around pointers and a count register; head is read combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: full_o deasserts acceptance; a push while full is taken only with a simultaneous pop.
module dsp_cmd_fifo
   import falconsoar_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     flush_i,
   input  logic     push_i,
   input  dsp_cmd_t wr_dat_i,
   input  logic     pop_i,
   output dsp_cmd_t rd_dat_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

   dsp_cmd_t         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o   = (count_q == DEPTH_C);
   assign empty_o  = (count_q == '0);
   assign pop_ok   = pop_i && !empty_o;
   assign push_ok  = push_i && (!full_o || pop_ok);
   assign rd_dat_o = mem_q[rd_ptr_q];

   // Occupancy next-state from the accepted push/pop pair
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and count update; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) begin
         mem_q[wr_ptr_q] <= wr_dat_i;
      end
   end

endmodule

// File: rtl/exec_task_dispatcher.sv
// Queues operator commands, issues each as a one-cycle start, waits for op_done, records latency, watchdogs hangs.
// Latency: accepted command into empty idle queue -> op_start high two edges later; op_done -> next op_start two edges later.
// Backpressure: cmd_ready drops while the command queue is full; the queue keeps accepting during the error state.
module exec_task_dispatcher
   import falconsoar_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int OP_W       = DSP_OP_W,
   parameter int ADDR_W     = DSP_ADDR_W,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   output logic              op_start,
   output logic [OP_W-1:0]   op_type,
   output logic [ADDR_W-1:0] op_src,
   output logic [ADDR_W-1:0] op_dst,
   input  logic              op_done,
   input  logic              abort,
   output logic              seq_busy,
   output logic              seq_done,
   output logic              seq_err,
   output logic [CNT_W-1:0]  last_cycles
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   dsp_state_e       state_q;
   dsp_cmd_t         op_cmd_q;
   logic             op_start_q, seq_done_q, seq_err_q;
   logic [CNT_W-1:0] cnt_q, last_cycles_q;

   dsp_cmd_t cmd_in, fifo_head;
   logic     fifo_full, fifo_empty, fifo_push, fifo_pop;

   // Pack the incoming command fields into the queue record
   always_comb begin
      cmd_in     = '0;
      cmd_in.op  = cmd_op;
      cmd_in.src = cmd_src;
      cmd_in.dst = cmd_dst;
   end

   // A command offered during abort is dropped; pops only happen from IDLE
   assign fifo_push = cmd_valid && !fifo_full && !abort;
   assign fifo_pop  = (state_q == DSP_IDLE) && !fifo_empty && !abort;

   dsp_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush_i  (abort),
      .push_i   (fifo_push),
      .wr_dat_i (cmd_in),
      .pop_i    (fifo_pop),
      .rd_dat_o (fifo_head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   // Dispatch FSM with latency counter and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= DSP_IDLE;
         op_cmd_q      <= '0;
         op_start_q    <= 1'b0;
         seq_done_q    <= 1'b0;
         seq_err_q     <= 1'b0;
         cnt_q         <= '0;
         last_cycles_q <= '0;
      end else begin
         op_start_q <= 1'b0;
         seq_done_q <= 1'b0;
         if (abort) begin
            state_q   <= DSP_IDLE;
            seq_err_q <= 1'b0;
            cnt_q     <= '0;
         end else begin
            case (state_q)
               DSP_IDLE: begin
                  if (!fifo_empty) begin
                     op_cmd_q   <= fifo_head;
                     op_start_q <= 1'b1;
                     state_q    <= DSP_ISSUE;
                  end
               end
               DSP_ISSUE: begin
                  cnt_q   <= '0;
                  state_q <= DSP_WAIT;
               end
               DSP_WAIT: begin
                  // Completion on the timeout edge still counts as a completion
                  if (op_done) begin
                     last_cycles_q <= cnt_q + 1'b1;
                     seq_done_q    <= 1'b1;
                     state_q       <= DSP_IDLE;
                  end else if (cnt_q == CNT_LAST) begin
                     seq_err_q <= 1'b1;
                     state_q   <= DSP_ERR;
                  end else if (cnt_q != CNT_MAX) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= DSP_ERR;
               end
            endcase
         end
      end
   end

   assign cmd_ready   = !fifo_full;
   assign op_start    = op_start_q;
   assign op_type     = op_cmd_q.op;
   assign op_src      = op_cmd_q.src;
   assign op_dst      = op_cmd_q.dst;
   assign seq_busy    = !fifo_empty || (state_q != DSP_IDLE);
   assign seq_done    = seq_done_q;
   assign seq_err     = seq_err_q;
   assign last_cycles = last_cycles_q;

endmodule

// File: tb/tb_exec_task_dispatcher.sv
// Bench for exec_task_dispatcher: directed scenarios with literal expectations plus random traffic.
// A task-level model (command queue plus age of the running task) predicts every output each cycle.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_exec_task_dispatcher;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = '0;
   logic [7:0] cmd_src = '0;
   logic [7:0] cmd_dst = '0;
   logic       op_start;
   logic [3:0] op_type;
   logic [7:0] op_src;
   logic [7:0] op_dst;
   logic       op_done = 1'b0;
   logic       abort = 1'b0;
   logic       seq_busy, seq_done, seq_err;
   logic [15:0] last_cycles;

   always #5 clk = ~clk;

   exec_task_dispatcher #(
      .FIFO_DEPTH (DEPTH),
      .OP_W       (4),
      .ADDR_W     (8),
      .CNT_W      (16),
      .TIMEOUT    (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_src     (cmd_src),
      .cmd_dst     (cmd_dst),
      .op_start    (op_start),
      .op_type     (op_type),
      .op_src      (op_src),
      .op_dst      (op_dst),
      .op_done     (op_done),
      .abort       (abort),
      .seq_busy    (seq_busy),
      .seq_done    (seq_done),
      .seq_err     (seq_err),
      .last_cycles (last_cycles)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- task-level model ----------------
   typedef struct packed {
      logic [3:0] op;
      logic [7:0] src;
      logic [7:0] dst;
   } tcmd_t;

   tcmd_t       mq[$];      // commands waiting in the queue
   tcmd_t       m_cur;      // task owned by the dispatcher
   bit          m_active;   // a task has been taken and not finished
   int          m_age;      // edges since the task was taken
   bit          m_err;
   bit          m_start, m_done, m_acc;
   logic [15:0] m_last;
   bit          chk_en = 1'b0;

   function automatic void model_reset();
      mq.delete();
      m_active = 1'b0;
      m_age    = 0;
      m_err    = 1'b0;
      m_start  = 1'b0;
      m_done   = 1'b0;
      m_acc    = 1'b0;
      m_last   = '0;
   endfunction

   // One clock edge of the task-level rules, using the inputs present at that edge
   function automatic void model_step();
      bit room = (mq.size() < DEPTH);
      m_start = 1'b0;
      m_done  = 1'b0;
      m_acc   = 1'b0;
      if (abort) begin
         mq.delete();
         m_active = 1'b0;
         m_err    = 1'b0;
         return;
      end
      if (m_active) begin
         // age 0 is the start cycle; the operator may only answer from age 1 on
         if (m_age >= 1 && op_done) begin
            m_last   = 16'(m_age);
            m_done   = 1'b1;
            m_active = 1'b0;
         end else if (m_age == TMO) begin
            m_err    = 1'b1;
            m_active = 1'b0;
         end else begin
            m_age++;
         end
      end else if (!m_err && mq.size() > 0) begin
         m_cur    = mq.pop_front();
         m_active = 1'b1;
         m_age    = 0;
         m_start  = 1'b1;
      end
      if (cmd_valid && room) begin
         mq.push_back({cmd_op, cmd_src, cmd_dst});
         m_acc = 1'b1;
      end
   endfunction

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_ready", cmd_ready, mq.size() < DEPTH);
         chk("cmp_start", op_start, m_start);
         chk("cmp_busy",  seq_busy, (mq.size() > 0) || m_active || m_err);
         chk("cmp_done",  seq_done, m_done);
         chk("cmp_err",   seq_err, m_err);
         chk("cmp_last",  last_cycles, m_last);
         if (m_active) begin
            chk("cmp_op_type", op_type, m_cur.op);
            chk("cmp_op_src",  op_src, m_cur.src);
            chk("cmp_op_dst",  op_dst, m_cur.dst);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] op, input logic [7:0] src, input logic [7:0] dst);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_src   = src;
      cmd_dst   = dst;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (m_acc) break;
      end
      if (!m_acc) chk("send_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_start"}, op_start, 0);
      chk({tag, "_ready"}, cmd_ready, 1);
      chk({tag, "_busy"},  seq_busy, 0);
      chk({tag, "_done"},  seq_done, 0);
      chk({tag, "_err"},   seq_err, 0);
      chk({tag, "_last"},  last_cycles, 0);
      chk({tag, "_type"},  op_type, 0);
      chk({tag, "_src"},   op_src, 0);
      chk({tag, "_dst"},   op_dst, 0);
   endtask

   int n_done;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("rst");
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // 1: single command, answer 5 cycles after start
      send(4'd3, 8'h10, 8'h20);
      chk("t1_no_start_yet", op_start, 0);
      cyc();
      chk("t1_start", op_start, 1);
      chk("t1_type", op_type, 3);
      chk("t1_src", op_src, 8'h10);
      chk("t1_dst", op_dst, 8'h20);
      cyc();
      chk("t1_start_one_cycle", op_start, 0);
      repeat (4) cyc();
      chk("t1_type_held", op_type, 3);
      chk("t1_dst_held", op_dst, 8'h20);
      op_done = 1'b1;
      cyc();
      op_done = 1'b0;
      chk("t1_seq_done", seq_done, 1);
      chk("t1_last", last_cycles, 5);
      cyc();
      chk("t1_seq_done_pulse", seq_done, 0);
      chk("t1_idle", seq_busy, 0);

      // 2: five commands with a stalled operator; queue fills, order preserved
      for (int i = 1; i <= 5; i++) send(4'(i), 8'(16 * i), 8'(16 * i + 1));
      chk("t2_full", cmd_ready, 0);
      chk("t2_first_type", op_type, 1);
      for (int i = 0; i < 5; i++) begin
         op_done = 1'b1;
         cyc();
         op_done = 1'b0;
         chk("t2_done", seq_done, 1);
         cyc();
         if (i < 4) begin
            chk("t2_gap_start", op_start, 1);
            chk("t2_order", op_type, i + 2);
         end else begin
            chk("t2_drained", seq_busy, 0);
         end
         cyc();
         cyc();
      end

      // 3: operator never answers -> watchdog error, then abort
      send(4'd6, 8'h66, 8'h67);
      cyc();
      chk("t3_start", op_start, 1);
      cyc();
      repeat (15) cyc();
      chk("t3_err_early", seq_err, 0);
      cyc();
      chk("t3_err", seq_err, 1);
      send(4'd2, 8'h22, 8'h23);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t3_no_start_in_err", op_start, 0);
      end
      chk("t3_busy_in_err", seq_busy, 1);
      abort     = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 4'd9;
      cyc();
      abort     = 1'b0;
      cmd_valid = 1'b0;
      chk("t3_err_cleared", seq_err, 0);
      chk("t3_busy_cleared", seq_busy, 0);
      cyc();
      chk("t3_abort_cmd_dropped", seq_busy, 0);

      // 4: completion exactly on the timeout edge
      send(4'd7, 8'h70, 8'h71);
      cyc();
      cyc();
      repeat (15) cyc();
      op_done = 1'b1;
      cyc();
      op_done = 1'b0;
      chk("t4_done", seq_done, 1);
      chk("t4_no_err", seq_err, 0);
      chk("t4_last", last_cycles, 16);

      // 5: reset during WAIT with three commands queued
      send(4'd8, 8'h80, 8'h81);
      cyc();
      cyc();
      send(4'd1, 8'h01, 8'h02);
      send(4'd2, 8'h03, 8'h04);
      send(4'd3, 8'h05, 8'h06);
      chk("t5_queued_busy", seq_busy, 1);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_reset_values("t5_rst");
      cyc();
      cyc();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t5_no_start_after_release", op_start, 0);
      end
      chk("t5_idle", seq_busy, 0);

      // 6: spurious op_done in IDLE, then a refill while the queue is full
      op_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t6_spurious_done", seq_done, 0);
      end
      op_done = 1'b0;
      chk("t6_last_unchanged", last_cycles, 0);
      send(4'd9, 8'h90, 8'h91);
      cyc();
      for (int i = 10; i <= 13; i++) send(4'(i), 8'(i), 8'(i + 100));
      chk("t6_full", cmd_ready, 0);
      cmd_valid = 1'b1;
      cmd_op    = 4'd14;
      cmd_src   = 8'hE0;
      cmd_dst   = 8'hE1;
      n_done    = 0;
      for (int i = 0; i < 300; i++) begin
         op_done = ((i % 3) == 0);
         cyc();
         if (m_acc) cmd_valid = 1'b0;
         if (seq_done) n_done++;
      end
      op_done   = 1'b0;
      cmd_valid = 1'b0;
      chk("t6_done_count", n_done, 6);
      chk("t6_idle", seq_busy, 0);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_op    = 4'($urandom);
         cmd_src   = 8'($urandom);
         cmd_dst   = 8'($urandom);
         op_done   = ($urandom_range(0, 9) < 2);
         abort     = (m_err && $urandom_range(0, 9) == 0) || ($urandom_range(0, 299) == 0);
         cyc();
      end
      cmd_valid = 1'b0;
      op_done   = 1'b0;
      abort     = 1'b0;
      cyc();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
